// File: rtl/em4100_sched_pkg.sv
// Shared types and constants for the EM4100 tag-ID scheduler.
package em4100_sched_pkg;

    localparam int TAG_W            = 40;
    localparam int FRAME_CYCLES_DEF = 74;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/em4100_sched_rr_pick.sv
// Round-robin finder: first set mask bit strictly after 'last', wrapping.
module rr_pick #(
    parameter  int SLOTS = 4,
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic [SLOTS-1:0] mask,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand_s;

    // Scan from farthest to nearest so the nearest candidate wins.
    always_comb begin
        idx    = '0;
        cand_s = '0;
        valid  = |mask;
        for (int i = SLOTS; i >= 1; i--) begin
            cand_s = IDX_W'((int'(last) + i) % SLOTS);
            if (mask[cand_s]) begin
                idx = cand_s;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/em4100_sched.sv
// EM4100 tag-ID scheduler: rotates stored IDs onto the encoder data/tx inputs
// in bursts of whole frames, with a programmable tx-low gap between bursts.
module em4100_sched
    import em4100_sched_pkg::*;
#(
    parameter  int SLOTS        = 4,
    parameter  int FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter  int REP_W        = 4,
    parameter  int GAP_W        = 8,
    localparam int IDX_W        = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [TAG_W-1:0] wr_data,
    input  logic [SLOTS-1:0] slot_mask,
    input  logic [REP_W-1:0] repeats,
    input  logic [GAP_W-1:0] gap,
    output logic             tx,
    output logic [TAG_W-1:0] data,
    output logic [IDX_W-1:0] slot,
    output logic             busy,
    output logic             frame_done
);

    localparam int               CYC_W    = $clog2(FRAME_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(FRAME_CYCLES - 1);

    state_t             state_r, state_s;
    logic [CYC_W-1:0]   cyc_r, cyc_s;
    logic [REP_W-1:0]   rep_r, rep_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               stop_r, stop_s;
    logic [IDX_W-1:0]   last_r;
    logic [TAG_W-1:0]   tbl_r [SLOTS];
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_vld_s;
    logic               go_s;
    logic               tx_r, busy_r, fd_r;
    logic [TAG_W-1:0]   data_r;
    logic [IDX_W-1:0]   slot_r;

    rr_pick #(.SLOTS(SLOTS)) u_pick (
        .mask  (slot_mask),
        .last  (last_r),
        .idx   (pick_idx_s),
        .valid (pick_vld_s)
    );

    assign go_s = en & pick_vld_s;

    // Next-state logic; stop_r remembers an en drop so the frame still finishes.
    always_comb begin
        state_s = state_r;
        cyc_s   = cyc_r;
        rep_s   = rep_r;
        gap_s   = gap_r;
        stop_s  = stop_r;
        case (state_r)
            IDLE: begin
                if (go_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (en) begin
                    state_s = SEND;
                    cyc_s   = '0;
                    rep_s   = (repeats == '0) ? REP_W'(1) : repeats;
                    stop_s  = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                stop_s = stop_r | ~en;
                if (cyc_r == CYC_LAST) begin
                    cyc_s = '0;
                    if (stop_r || !en) begin
                        state_s = IDLE;
                    end else if (rep_r > REP_W'(1)) begin
                        rep_s = rep_r - REP_W'(1);
                    end else if (gap != '0) begin
                        state_s = GAP;
                        gap_s   = gap;
                    end else if (pick_vld_s) begin
                        state_s = LOAD;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            GAP: begin
                if (!en) begin
                    state_s = IDLE;
                end else if (gap_r == GAP_W'(1)) begin
                    state_s = go_s ? LOAD : IDLE;
                end else begin
                    gap_s = gap_r - GAP_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cyc_r   <= '0;
            rep_r   <= '0;
            gap_r   <= '0;
            stop_r  <= 1'b0;
            last_r  <= IDX_W'(SLOTS - 1);
            tx_r    <= 1'b0;
            busy_r  <= 1'b0;
            fd_r    <= 1'b0;
            data_r  <= '0;
            slot_r  <= '0;
        end else begin
            state_r <= state_s;
            cyc_r   <= cyc_s;
            rep_r   <= rep_s;
            gap_r   <= gap_s;
            stop_r  <= stop_s;
            tx_r    <= (state_s == SEND);
            busy_r  <= (state_s != IDLE);
            fd_r    <= (state_s == SEND) && (cyc_s == CYC_LAST);
            if (state_s == LOAD) begin
                data_r <= tbl_r[pick_idx_s];
                slot_r <= pick_idx_s;
                last_r <= pick_idx_s;
            end
        end
    end

    // ID table; a write lands on the same edge a LOAD reads, so LOAD sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                tbl_r[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_r[wr_addr] <= wr_data;
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign frame_done = fd_r;
    assign data       = data_r;
    assign slot       = slot_r;

endmodule

// File: tb/tb_em4100_sched.sv
// Directed bench for em4100_sched: burst-shape vector table plus corner sequences.
module tb_em4100_sched;

    logic        clk = 1'b0;
    logic        rst, en, wr_en;
    logic [1:0]  wr_addr;
    logic [39:0] wr_data;
    logic [3:0]  slot_mask;
    logic [3:0]  repeats;
    logic [7:0]  gap;
    logic        tx, busy, frame_done;
    logic [39:0] data;
    logic [1:0]  slot;

    int total = 0;
    int bad   = 0;

    logic [39:0] tv [4];

    typedef struct {
        logic [3:0] mask;
        logic [3:0] reps;
        logic [7:0] gap;
        int         s1;
        int         high;
        int         fds;
        int         low;
        int         s2;
    } vec_t;

    vec_t vt [6];

    em4100_sched dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .slot_mask  (slot_mask),
        .repeats    (repeats),
        .gap        (gap),
        .tx         (tx),
        .data       (data),
        .slot       (slot),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; wr_en = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_all();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 2'(i); wr_data = tv[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        logic [39:0] d1, d2, dl;
        int s1, s2, high, fds, fdlast, low, n;
        logic ok;

        tv[0] = 40'h0123456789; tv[1] = 40'hA5A5A5A5A5;
        tv[2] = 40'h1122334455; tv[3] = 40'hDEADBEEF00;
        vt[0] = '{4'b0011, 4'd2,  8'd5, 0, 148,  2,  6, 1};
        vt[1] = '{4'b0100, 4'd0,  8'd0, 2, 74,   1,  1, 2};
        vt[2] = '{4'b1000, 4'd1,  8'd3, 3, 74,   1,  4, 3};
        vt[3] = '{4'b1010, 4'd3,  8'd1, 1, 222,  3,  2, 3};
        vt[4] = '{4'b1001, 4'd1,  8'd0, 0, 74,   1,  1, 3};
        vt[5] = '{4'b0110, 4'd15, 8'd2, 1, 1110, 15, 3, 2};

        rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 40'd0;
        slot_mask = 4'd0; repeats = 4'd0; gap = 8'd0;
        do_reset();
        chk("rst_tx", 64'(tx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_slot", 64'(slot), 64'd0);
        chk("rst_fd", 64'(frame_done), 64'd0);

        // Burst-shape table: first LOAD, tx-high run, frame_done pulses, low run, next LOAD.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            write_all();
            slot_mask = vt[v].mask; repeats = vt[v].reps; gap = vt[v].gap;
            en = 1'b1;
            tick();
            s1 = int'(slot); d1 = data;
            tick();
            high = 0; fds = 0; fdlast = 0; n = 0;
            while (tx === 1'b1 && n < 3000) begin
                high++;
                if (frame_done === 1'b1) begin fds++; fdlast = high; end
                tick(); n++;
            end
            low = 0; s2 = -1; d2 = 40'd0;
            while (tx === 1'b0 && busy === 1'b1 && n < 3000) begin
                low++; s2 = int'(slot); d2 = data;
                tick(); n++;
            end
            en = 1'b0;
            chk($sformatf("v%0d_timeout", v), 64'(n < 3000), 64'd1);
            chk($sformatf("v%0d_s1", v), 64'(s1), 64'(vt[v].s1));
            chk($sformatf("v%0d_d1", v), 64'(d1), 64'(tv[vt[v].s1]));
            chk($sformatf("v%0d_high", v), 64'(high), 64'(vt[v].high));
            chk($sformatf("v%0d_fds", v), 64'(fds), 64'(vt[v].fds));
            chk($sformatf("v%0d_fdlast", v), 64'(fdlast), 64'(vt[v].high));
            chk($sformatf("v%0d_low", v), 64'(low), 64'(vt[v].low));
            chk($sformatf("v%0d_s2", v), 64'(s2), 64'(vt[v].s2));
            chk($sformatf("v%0d_d2", v), 64'(d2), 64'(tv[vt[v].s2]));
        end

        // Empty mask holds IDLE; setting bit 3 loads slot 3 next cycle, tx the one after.
        do_reset(); write_all();
        slot_mask = 4'b0000; repeats = 4'd1; gap = 8'd0; en = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy !== 1'b0 || tx !== 1'b0) ok = 1'b0;
        end
        chk("m0_idle", 64'(ok), 64'd1);
        slot_mask = 4'b1000;
        tick();
        chk("m8_busy", 64'(busy), 64'd1);
        chk("m8_tx_load", 64'(tx), 64'd0);
        chk("m8_slot", 64'(slot), 64'd3);
        tick();
        chk("m8_tx_send", 64'(tx), 64'd1);
        en = 1'b0;

        // en dropped mid-frame: frame completes, then straight to IDLE.
        do_reset(); write_all();
        slot_mask = 4'b0001; repeats = 4'd2; gap = 8'd4; en = 1'b1;
        tick();
        chk("stop_load_busy", 64'(busy), 64'd1);
        ok = 1'b1;
        for (int c = 1; c <= 74; c++) begin
            tick();
            if (tx !== 1'b1) ok = 1'b0;
            if (c < 74 && frame_done !== 1'b0) ok = 1'b0;
            if (c == 30) en = 1'b0;
        end
        chk("stop_tx_held", 64'(ok), 64'd1);
        chk("stop_fd", 64'(frame_done), 64'd1);
        tick();
        chk("stop_idle_busy", 64'(busy), 64'd0);
        chk("stop_idle_tx", 64'(tx), 64'd0);

        // Table write during a burst only shows at that slot's next LOAD.
        do_reset(); write_all();
        slot_mask = 4'b0001; repeats = 4'd1; gap = 8'd2; en = 1'b1;
        tick();
        chk("wr_load_data", 64'(data), 64'(tv[0]));
        tick();
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 40'hFFFFFFFFFF;
        tick();
        wr_en = 1'b0;
        ok = 1'b1; n = 0;
        while (tx === 1'b1 && n < 200) begin
            if (data !== tv[0]) ok = 1'b0;
            tick(); n++;
        end
        chk("wr_data_held", 64'(ok), 64'd1);
        dl = 40'd0;
        while (tx === 1'b0 && busy === 1'b1 && n < 200) begin
            dl = data; tick(); n++;
        end
        chk("wr_bound", 64'(n < 200), 64'd1);
        chk("wr_next_load", 64'(dl), 64'hFFFFFFFFFF);
        en = 1'b0;

        // Reset mid-SEND clears outputs and the table.
        do_reset(); write_all();
        slot_mask = 4'b0011; repeats = 4'd1; gap = 8'd0; en = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("rs_pre_tx", 64'(tx), 64'd1);
        rst = 1'b1;
        tick();
        chk("rs_tx", 64'(tx), 64'd0);
        chk("rs_busy", 64'(busy), 64'd0);
        chk("rs_data", 64'(data), 64'd0);
        chk("rs_fd", 64'(frame_done), 64'd0);
        rst = 1'b0;
        tick();
        chk("rs_reload_busy", 64'(busy), 64'd1);
        chk("rs_reload_slot", 64'(slot), 64'd0);
        chk("rs_reload_data", 64'(data), 64'd0);
        en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/em4100_sched.md
EM4100_SCHED -- requirements
Module: em4100_sched

Interface
REQ-001 Parameter SLOTS, default 4: number of stored tag IDs.
REQ-002 Parameter FRAME_CYCLES, default 74: encoder clocks per frame (9 header, 54 data, 2 stop, 9 pause).
REQ-003 Parameter REP_W, default 4: width of the repeat-count input.
REQ-004 Parameter GAP_W, default 8: width of the inter-ID gap input.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port en, input, 1 bit: scheduler run enable.
REQ-008 Port wr_en, input, 1 bit: writes wr_data into the ID table.
REQ-009 Port wr_addr, input, clog2(SLOTS) bits: table slot to write.
REQ-010 Port wr_data, input, 40 bits: tag ID to store.
REQ-011 Port slot_mask, input, SLOTS bits: a 1 means the slot takes part in the rotation.
REQ-012 Port repeats, input, REP_W bits: frames sent per ID; 0 is treated as 1.
REQ-013 Port gap, input, GAP_W bits: extra tx-low cycles after each ID burst.
REQ-014 Port tx, output, 1 bit: drives the encoder tx input.
REQ-015 Port data, output, 40 bits: drives the encoder data input.
REQ-016 Port slot, output, clog2(SLOTS) bits: index of the slot currently presented on data.
REQ-017 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-018 Port frame_done, output, 1 bit: one-cycle pulse on the last cycle of each transmitted frame.

Function
REQ-019 The block SHALL implement the states IDLE, LOAD, SEND and GAP.
REQ-020 IDLE SHALL go to LOAD when en=1 and slot_mask is non-zero; otherwise it SHALL stay in IDLE.
REQ-021 Next-slot selection SHALL be round-robin: the first set bit of slot_mask after the last served slot, wrapping from SLOTS-1 to 0.
REQ-022 LOAD SHALL last exactly 1 cycle, with tx=0 and the selected table entry registered onto data and slot, so the encoder captures parity while tx is low.
REQ-023 SEND SHALL hold tx=1 for exactly max(repeats,1)*FRAME_CYCLES cycles.
REQ-024 frame_done SHALL pulse on every FRAME_CYCLES-th SEND cycle.
REQ-025 repeats SHALL be sampled in LOAD and held for the whole burst.
REQ-026 After SEND, GAP SHALL hold tx=0 for gap cycles, with gap sampled on SEND exit.
REQ-027 When gap=0, SEND SHALL go straight to the next LOAD.
REQ-028 On GAP exit (or on SEND exit when gap=0), the block SHALL go to LOAD if en=1 and slot_mask is non-zero, else to IDLE.
REQ-029 If en falls during SEND, the current frame SHALL complete (up to and including the frame_done cycle), then the block SHALL go directly to IDLE with no GAP.
REQ-030 If en falls during LOAD or GAP, the block SHALL go to IDLE on the next cycle.
REQ-031 A slot_mask change SHALL affect only the next selection; the active burst SHALL continue.
REQ-032 A table write SHALL take effect at the next LOAD of that slot; data SHALL stay unchanged through the current burst.
REQ-033 A write to the slot being loaded in the same cycle: LOAD SHALL capture the old value.
REQ-034 If only one mask bit is set, the same slot SHALL repeat with LOAD/GAP between bursts.
REQ-035 Latency: from en rising in IDLE, LOAD SHALL follow 1 cycle later and tx=1 2 cycles later.

Reset
REQ-036 While rst=1, the block SHALL enter IDLE with tx=0, data=0, slot=0, busy=0 and frame_done=0.
REQ-037 Reset SHALL clear all ID table entries to 0.
REQ-038 Reset SHALL set the last-served pointer to SLOTS-1, so slot 0 is considered first.
REQ-039 Reset mid-SEND SHALL force tx=0 on the following cycle, and no frame_done pulse SHALL be emitted.

Structure
REQ-040 A shared package SHALL hold the state enumeration, the FRAME_CYCLES constant (74) and the 40-bit tag-ID width.
REQ-041 The round-robin next-slot finder SHALL be a sub-module, rr_pick (mask and last pointer in; index and valid out).
REQ-042 The encoder SHALL NOT be instantiated inside this block; tx, data and the encoder share the top-level clk.

Verification
REQ-043 Write slot0=0x0123456789 and slot1=0xA5A5A5A5A5, mask=0011, repeats=2, gap=5, en=1 -> sequence LOAD(slot0), 148 tx-high cycles with 2 frame_done pulses, 5 tx-low cycles, LOAD(slot1).
REQ-044 mask=0100, repeats=0 -> slot=2 on every burst, 74 tx-high cycles per burst.
REQ-045 en dropped at SEND cycle 30 of frame 1 -> tx stays high until cycle 74, frame_done pulses, IDLE on the next cycle, busy=0.
REQ-046 wr_en to slot 0 with 0xFFFFFFFFFF during slot 0's SEND -> data unchanged for that burst and 0xFFFFFFFFFF on slot 0's next LOAD.
REQ-047 rst asserted mid-SEND -> next cycle tx=0, busy=0, data=0, and the table reads 0 on the next LOAD.
REQ-048 mask=0000 with en=1 -> stays in IDLE, tx=0; mask then set to 1000 -> LOAD(slot3) on the next cycle.
